serial_mag_compare: RTL
=======================

Name: serial_mag_compare

Overview:
- Multi-cycle magnitude comparator for WIDTH-bit unsigned operands.
- Compares the operands 2 bits per cycle, most significant slice first, through one shared 2-bit comparator slice (LT/EQ/GrT semantics).
- Terminates early on the first unequal slice.
- Used wherever a wide compare is needed but only one 2-bit compare resource is available; a start/done handshake sequences it.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 2.
- NSLICE, WIDTH/2, number of 2-bit slices; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request a compare; sampled only in IDLE
- a  input  WIDTH  operand A; latched on accepted start
- b  input  WIDTH  operand B; latched on accepted start
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse; result valid
- LT  output  1  A < B, registered
- EQ  output  1  A == B, registered
- GrT  output  1  A > B, registered

Behaviour:
- Reset, asynchronous, any state:
  - state=IDLE, slice index=NSLICE-1.
  - Operand regs cleared.
  - busy=0, done=0, LT=0, EQ=0, GrT=0.
  - An in-flight compare is abandoned; no done pulse is produced.
- States: IDLE, COMPARE, DONE.
- IDLE:
  - start=1 at a clock edge latches a, b and sets idx=NSLICE-1; next state COMPARE.
  - start=0: stay in IDLE.
- COMPARE, each cycle: the shared slice compares a_q[2*idx+1:2*idx] against b_q[2*idx+1:2*idx].
  - Slice GrT or LT: register GrT/LT=1, clear the other two result bits; next state DONE.
  - Slice EQ and idx==0: register EQ=1, LT=0, GrT=0; next state DONE.
  - Slice EQ and idx>0: idx decrements; stay in COMPARE.
- DONE: done=1 for exactly this cycle; next state IDLE unconditionally.
- Results:
  - Exactly one of LT/EQ/GrT is 1 after the first completed compare.
  - All three stay 0 from reset until the first done.
  - Results are updated only on the edge entering DONE and hold until the next done.
  - A new start does not clear them.
- Latency, with start sampled at edge 0 and k = number of slices examined (1..NSLICE):
  - done is high in the cycle after edge k+1.
  - Minimum 2 cycles, start edge to done edge; maximum NSLICE+1.
- busy rises in the cycle after start is accepted and falls when DONE exits.
- start while busy (COMPARE or DONE) is ignored, not queued.
- a/b changes after acceptance have no effect.
- start held continuously: re-accepted on the first IDLE cycle after DONE, giving back-to-back compares with a 1-cycle IDLE gap.
- WIDTH=2: single COMPARE cycle, latency 2.
- No X outputs under any defined input; X on a/b at acceptance is out of scope.

Test Plan (WIDTH=8):
- Reset, then a=0xC3, b=0x43, 1-cycle start: first slice 11 vs 01 gives GrT=1, LT=0, EQ=0; done 2 cycles after start; busy high 2 cycles.
- a=0x12, b=0x13: slices 00, 01, 00 equal, last slice 10 vs 11 gives LT=1; done exactly 5 cycles after start.
- a=0x5A, b=0x5A: EQ=1 after all 4 slices; done at cycle 5. Then a=0x00, b=0x00 gives EQ=1 again, and the results stay EQ between the two dones.
- Operands/start ignored while busy: start a=0x80, b=0x7F; next cycle drive a=0x00 with start=1. Required: GrT=1 at done, and only one done pulse.
- start held high with a=0x01, b=0x02 repeatedly: done pulses every 6 cycles (5 latency + 1 IDLE), LT=1 each time.
- Reset mid-op: a=0x11, b=0x11, assert rst 2 cycles after start. Required: busy=0, all results 0, no done pulse; a fresh compare after reset works normally.

Source files
------------

// File: rtl/serial_mag_compare.sv
`default_nettype none
// ============================================================================
//  Module   : serial_mag_compare
//  Purpose  : Multi-cycle unsigned magnitude comparator. Operands are walked
//             two bits per cycle, most significant slice first, through a
//             single shared 2-bit comparator slice. The walk stops on the
//             first unequal slice. A start/done handshake sequences it.
//  Ports    : clk   - rising-edge clock
//             rst   - asynchronous, active-high reset
//             start - compare request, sampled only while idle
//             a, b  - WIDTH-bit operands, latched when start is accepted
//             busy  - high while a compare is in progress (COMPARE or DONE)
//             done  - one-cycle pulse, results valid
//             LT/EQ/GrT - registered result (A<B / A==B / A>B), held until
//                     the next done
//  Revision : 1.0 - initial release
// ============================================================================
module serial_mag_compare #(
  parameter int WIDTH = 8  // must be even and >= 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             LT,
  output logic             EQ,
  output logic             GrT
);

  localparam int NSLICE = WIDTH / 2;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NSLICE - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPARE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDXW-1:0]  idx_q,   idx_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic             lt_q,    lt_d;
  logic             eq_q,    eq_d;
  logic             gt_q,    gt_d;

  // Operand registers viewed as arrays of 2-bit slices so the shared
  // comparator can pick its slice with a plain array index.
  logic [1:0] a_slice [NSLICE];
  logic [1:0] b_slice [NSLICE];

  for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
    assign a_slice[gi] = a_q[2*gi +: 2];
    assign b_slice[gi] = b_q[2*gi +: 2];
  end

  // The one shared 2-bit comparator slice.
  logic [1:0] sa, sb;
  logic       slice_lt, slice_gt;

  assign sa       = a_slice[idx_q];
  assign sb       = b_slice[idx_q];
  assign slice_lt = (sa < sb);
  assign slice_gt = (sa > sb);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          idx_d   = IDX_TOP;
          state_d = S_COMPARE;
        end
      end

      S_COMPARE: begin
        if (slice_lt || slice_gt) begin
          // First unequal slice decides the whole compare.
          lt_d    = slice_lt;
          gt_d    = slice_gt;
          eq_d    = 1'b0;
          state_d = S_DONE;
        end else if (idx_q == '0) begin
          // Every slice matched, down to the least significant one.
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          eq_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - IDXW'(1);
        end
      end

      S_DONE: begin
        // start is deliberately ignored here; it is seen again next cycle.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= IDX_TOP;
      a_q     <= '0;
      b_q     <= '0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign LT   = lt_q;
  assign EQ   = eq_q;
  assign GrT  = gt_q;

endmodule
`default_nettype wire
